// File: rtl/pll_reset_pkg.sv
// Shared types, defaults and helpers for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        DEBOUNCE,
        READY,
        FAULT
    } pll_state_e;

    localparam int unsigned DEF_RST_PULSE_CYCLES    = 50;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_MAX_RETRIES         = 7;

    // Width of a down-counter that must hold (largest cycle count - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow status bits; resets to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops give metastability time to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a
// debounced lock, retries on timeout and reports readiness, faults and losses.
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_relock,
    output logic       pll_rst,
    output logic       clk_ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned CNT_W =
        cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, clk_ready_q, fault_q;
    logic             locked_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

    // Next-state, shared counter reload and retry/loss bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_q == '0) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = RESET_PLL;
                        cnt_d   = RST_LOAD;
                    end
                end
            end
            DEBOUNCE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    retry_d = '0;
                    state_d = RESET_PLL;
                    cnt_d   = RST_LOAD;
                end
            end
            FAULT: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = RST_LOAD;
            end
        endcase

        // Relock overrides the state decision but a simultaneous loss is still counted.
        if (req_relock) begin
            retry_d = '0;
            state_d = RESET_PLL;
            cnt_d   = RST_LOAD;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= RST_LOAD;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
            clk_ready_q <= (state_d == READY);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign clk_ready       = clk_ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl with shortened timing parameters.
module tb_pll_reset_ctrl;

    localparam int unsigned RST_P = 4;
    localparam int unsigned TMO   = 20;
    localparam int unsigned STB   = 8;
    localparam int unsigned MAXR  = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req_relock = 1'b0;
    logic       pll_rst;
    logic       clk_ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYCLES   (RST_P),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .LOCK_STABLE_CYCLES (STB),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .req_relock     (req_relock),
        .pll_rst        (pll_rst),
        .clk_ready      (clk_ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic       rst;
        logic       locked;
        logic       relock;
        int         reps;
        logic       e_pll_rst;
        logic       e_ready;
        logic       e_fault;
        logic [3:0] e_retry;
        logic [7:0] e_loss;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic lk, input logic rl, input int reps,
                       input logic pr, input logic rdy, input logic flt,
                       input logic [3:0] rc, input logic [7:0] loss);
        vec_t v;
        v.rst = r; v.locked = lk; v.relock = rl; v.reps = reps;
        v.e_pll_rst = pr; v.e_ready = rdy; v.e_fault = flt;
        v.e_retry = rc; v.e_loss = loss;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic pr, input logic rdy, input logic flt,
                           input logic [3:0] rc, input logic [7:0] loss);
        chk({name, ".pll_rst"}, 32'(pll_rst), 32'(pr));
        chk({name, ".clk_ready"}, 32'(clk_ready), 32'(rdy));
        chk({name, ".fault"}, 32'(fault), 32'(flt));
        chk({name, ".retry_count"}, 32'(retry_count), 32'(rc));
        chk({name, ".lock_loss_count"}, 32'(lock_loss_count), 32'(loss));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (clk_ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({name, ".ready_reached"}, 32'(clk_ready), 32'd1);
    endtask

    task automatic wait_pll_rst(input logic val, input int budget, input string name);
        int n = 0;
        while (pll_rst !== val && n < budget) begin
            step();
            n++;
        end
        chk({name, ".pll_rst_reached"}, 32'(pll_rst), 32'(val));
    endtask

    task automatic wait_fault(input int budget, input string name);
        int n = 0;
        while (fault !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({name, ".fault_reached"}, 32'(fault), 32'd1);
    endtask

    // Expects clk_ready low for n-1 samples and high on the n-th.
    task automatic expect_ready_after(input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            step();
            chk($sformatf("%s.c%0d", name, i), 32'(clk_ready), 32'(i == n));
        end
    endtask

    initial begin
        // rst lk rl reps | pll_rst ready fault retry loss
        add(1, 0, 0,  2, 1, 0, 0, 0, 0);  // reset state
        add(0, 0, 0,  3, 1, 0, 0, 0, 0);  // rest of 4-cycle pulse
        add(0, 0, 0,  1, 0, 0, 0, 0, 0);  // pll_rst falls
        add(0, 0, 0,  4, 0, 0, 0, 0, 0);  // waiting, no lock yet
        add(0, 1, 0, 10, 0, 0, 0, 0, 0);  // lock rises, sync + debounce
        add(0, 1, 0,  1, 0, 1, 0, 0, 0);  // ready on 11th cycle
        add(0, 1, 0,  3, 0, 1, 0, 0, 0);
        add(0, 0, 0,  1, 0, 1, 0, 0, 0);  // one-cycle lock drop
        add(0, 1, 0,  1, 0, 1, 0, 0, 0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 1);  // loss seen on 3rd cycle
        add(0, 1, 0,  3, 1, 0, 0, 0, 1);
        add(0, 1, 0,  1, 0, 0, 0, 0, 1);
        add(0, 1, 0,  8, 0, 0, 0, 0, 1);  // lock already synced: debounce
        add(0, 1, 0,  1, 0, 1, 0, 0, 1);
        add(0, 1, 1,  1, 1, 0, 0, 0, 1);  // relock from READY, no loss
        add(0, 1, 0,  3, 1, 0, 0, 0, 1);
        add(0, 1, 0,  1, 0, 0, 0, 0, 1);
        add(0, 1, 0,  8, 0, 0, 0, 0, 1);
        add(0, 1, 0,  1, 0, 1, 0, 0, 1);
        add(0, 0, 0,  1, 0, 1, 0, 0, 1);  // drop, then relock on loss cycle
        add(0, 1, 0,  1, 0, 1, 0, 0, 1);
        add(0, 1, 1,  1, 1, 0, 0, 0, 2);  // one transition, loss counted
        add(0, 1, 0,  3, 1, 0, 0, 0, 2);
        add(0, 1, 0,  1, 0, 0, 0, 0, 2);
        add(0, 1, 0,  8, 0, 0, 0, 0, 2);
        add(0, 1, 0,  1, 0, 1, 0, 0, 2);

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            pll_locked = vecs[i].locked;
            req_relock = vecs[i].relock;
            for (int r = 0; r < vecs[i].reps; r++) begin
                step();
                req_relock = 1'b0;
                chk_all($sformatf("vec%0d.%0d", i, r), vecs[i].e_pll_rst, vecs[i].e_ready,
                        vecs[i].e_fault, vecs[i].e_retry, vecs[i].e_loss);
            end
        end

        // Glitchy lock: 3 high, 2 low, then steady high.
        pll_locked = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("glitch.pulse%0d", i), 32'(pll_rst), 32'd1);
        end
        step();
        chk("glitch.pulse_end", 32'(pll_rst), 32'd0);
        for (int i = 0; i < 5; i++) step();
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pll_locked = 1'b0;
        for (int i = 0; i < 2; i++) step();
        pll_locked = 1'b1;
        expect_ready_after(11, "glitch");

        // Retry then fault with lock held low.
        pll_locked = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("retry.pulse0.%0d", i), 32'(pll_rst), 32'd1);
        end
        for (int t = 0; t <= int'(MAXR); t++) begin
            for (int i = 0; i < int'(TMO); i++) begin
                step();
                chk($sformatf("retry.wait%0d.%0d.pll_rst", t, i), 32'(pll_rst), 32'd0);
                chk($sformatf("retry.wait%0d.%0d.retry", t, i), 32'(retry_count), 32'(t));
            end
            if (t < int'(MAXR)) begin
                for (int i = 0; i < int'(RST_P); i++) begin
                    step();
                    chk($sformatf("retry.pulse%0d.%0d.pll_rst", t + 1, i), 32'(pll_rst), 32'd1);
                    chk($sformatf("retry.pulse%0d.%0d.retry", t + 1, i), 32'(retry_count),
                        32'(t + 1));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("fault.hold%0d", i), 1, 0, 1, 4'(MAXR), 0);
        end

        // Fault recovery via relock.
        pll_locked = 1'b1;
        req_relock = 1'b1;
        step();
        req_relock = 1'b0;
        chk_all("recover.relock", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("recover.pulse%0d", i), 32'(pll_rst), 32'd1);
        end
        step();
        chk("recover.pulse_end", 32'(pll_rst), 32'd0);
        wait_ready(20, "recover");

        // Repeated lock loss while ready; counter saturates.
        for (int i = 0; i < 300; i++) begin
            int n;
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            n = 1;
            while (clk_ready === 1'b1 && n < 3) begin
                step();
                n++;
            end
            chk($sformatf("loss%0d.ready_fell", i), 32'(clk_ready), 32'd0);
            chk($sformatf("loss%0d.count", i), 32'(lock_loss_count),
                (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            if (i == 0) chk("loss0.pll_rst", 32'(pll_rst), 32'd1);
            wait_ready(30, $sformatf("loss%0d", i));
        end

        // Reset during DEBOUNCE.
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_pll_rst(1'b1, 5, "mid_deb.rise");
        wait_pll_rst(1'b0, 10, "mid_deb.fall");
        step();
        step();
        chk("mid_deb.pre_loss", 32'(lock_loss_count), 32'd255);
        rst = 1'b1;
        step();
        chk_all("mid_deb.reset", 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset during FAULT.
        pll_locked = 1'b0;
        wait_fault(200, "mid_fault");
        chk("mid_fault.pre_retry", 32'(retry_count), 32'(MAXR));
        rst = 1'b1;
        step();
        chk_all("mid_fault.reset", 1, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer and lock supervisor for the system PLL. It runs on the 50 MHz reference clock and drives the PLL reset input. It synchronises and debounces the PLL `locked` output, retries failed lock attempts, and raises a single `clk_ready` qualifier. Downstream logic uses `clk_ready` to release its own resets in the 10 MHz output domain.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 50: PLL reset pulse width in refclk cycles (1 µs).
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum wait for `locked` after the reset pulse (1 ms).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before ready.
- `MAX_RETRIES`, 7: reset re-attempts after timeout before declaring fault.

Ports:
- `refclk`, in, 1: 50 MHz reference clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL `locked`; asynchronous to `refclk`.
- `req_relock`, in, 1: single-cycle request to re-run the full sequence.
- `pll_rst`, out, 1: registered reset to the PLL, active-high.
- `clk_ready`, out, 1: PLL output clock is locked and stable.
- `fault`, out, 1: retries exhausted; sticky.
- `retry_count`, out, 4: timeouts in the current sequence.
- `lock_loss_count`, out, 8: saturating count of lock losses while ready.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to produce `locked_s`. No other logic samples the raw input.
- One shared down-counter `cnt` is sized to `$clog2` of the largest cycle parameter. It is reloaded on every state entry.
- **Reset values:** state RESET_PLL, `cnt` = RST_PULSE_CYCLES−1, `pll_rst`=1, `clk_ready`=0, `fault`=0, `retry_count`=0, `lock_loss_count`=0, synchroniser flops=0.
- **RESET_PLL:** `pll_rst`=1.
  - When `cnt`==0, go to WAIT_LOCK with `cnt` = LOCK_TIMEOUT_CYCLES−1.
- **WAIT_LOCK:** `pll_rst`=0.
  - If `locked_s`=1, go to DEBOUNCE with `cnt` = LOCK_STABLE_CYCLES−1.
  - Otherwise, when `cnt`==0 and `retry_count`==MAX_RETRIES, go to FAULT.
  - Otherwise, when `cnt`==0, increment `retry_count` and go to RESET_PLL.
- **DEBOUNCE:**
  - If `locked_s`=0, go to WAIT_LOCK and reload the full timeout.
  - If `cnt`==0 with `locked_s`=1, go to READY.
- **READY:** `clk_ready`=1.
  - If `locked_s`=0: increment `lock_loss_count` (saturates at 255), clear `retry_count`, go to RESET_PLL.
- **FAULT:** `pll_rst`=1 and `fault`=1. Exit only via `rst` or `req_relock`.
- **`req_relock` in any state:**
  - Clears `retry_count` and `fault`.
  - Enters RESET_PLL with a fresh pulse.
  - In RESET_PLL, it restarts the pulse.
- **Simultaneous lock loss and `req_relock` in READY:** one transition to RESET_PLL; the loss is still counted.
- `rst` has priority over every other input.

## Timing
- All outputs are registered and change on the clock edge after the state transition decision.
- `pll_rst` stays high for exactly RST_PULSE_CYCLES cycles, starting from the first cycle after `rst` deasserts.
- Latency from `pll_locked` rising to `clk_ready`=1 is 2 synchroniser cycles + LOCK_STABLE_CYCLES + 1 registered-output cycle. This assumes `locked` stays high throughout.
- `clk_ready` falls no more than 3 cycles after `pll_locked` falls: 2 synchroniser cycles plus 1 output register.
- A timeout costs LOCK_TIMEOUT_CYCLES cycles in WAIT_LOCK, then a new RST_PULSE_CYCLES reset pulse.
- FAULT is reached after MAX_RETRIES+1 total timeouts.
- A `req_relock` pulse is sampled on the edge where it is high; `pll_rst` rises the next cycle.

## Structure
- Package `pll_reset_pkg`:
  - state enum `{RESET_PLL, WAIT_LOCK, DEBOUNCE, READY, FAULT}`;
  - default parameter constants;
  - counter-width function.
- Sub-module `sync_2ff`: generic 2-flop synchroniser, reset to 0. It is reused later for other cross-domain status bits.
- Everything else (FSM, counter, retry and loss counters) lives in `pll_reset_ctrl`.

## Test plan
The bench uses RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- **Nominal lock:** release `rst`; raise `pll_locked` 5 cycles after `pll_rst` falls, hold high → `pll_rst` high for 4 cycles, `clk_ready`=1 exactly 11 cycles after `pll_locked` rises, `retry_count`=0.
- **Glitchy lock:** `pll_locked` high for 3 cycles, low for 2, then high steadily → DEBOUNCE aborts to WAIT_LOCK; `clk_ready` rises 11 cycles after the final rising edge.
- **Retry then fault:** hold `pll_locked`=0 → three 20-cycle waits separated by 4-cycle `pll_rst` pulses. `retry_count` steps 1, then 2. Then `fault`=1 with `pll_rst`=1 held.
- **Fault recovery:** in FAULT, pulse `req_relock`, then provide lock → `fault`=0 and `retry_count`=0 next cycle, fresh 4-cycle pulse, `clk_ready` rises.
- **Lock loss while ready:** drop `pll_locked` for 1 cycle → `clk_ready`=0 within 3 cycles, `lock_loss_count`=1, new 4-cycle `pll_rst` pulse. Repeat 300 times → counter holds at 255.
- **Reset mid-sequence:** assert `rst` during DEBOUNCE and during FAULT → the next cycle shows all reset values, including counters at 0 and `pll_rst`=1.
